// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; the caller owns the last-winner register.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_grant  = 2'b00;
        o_winner = M_CPU;
        case (i_req)
            2'b01: begin
                o_grant  = 2'b01;
                o_winner = M_CPU;
            end
            2'b10: begin
                o_grant  = 2'b10;
                o_winner = M_LDR;
            end
            2'b11: begin
                // under contention the master that did not go last wins
                if (i_last == M_CPU) begin
                    o_grant  = 2'b10;
                    o_winner = M_LDR;
                end else begin
                    o_grant  = 2'b01;
                    o_winner = M_CPU;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the single synchronous memory port between CPU (m0) and loader (m1).
//   state    | meaning
//   ST_IDLE  | waiting for a request; grant issued combinationally here
//   ST_ISSUE | latched access presented to mem (write mask or read strobe)
//   ST_RDATA | mem read data routed to the owning master
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESET_LAST = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_m0_req,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_wmask,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,

    input  logic                i_m1_req,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wmask,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,

    output logic                o_mem_strb,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int   MASK_W       = DATA_W / 8;
    localparam logic RESET_LAST_B = (RESET_LAST != 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_winner;
    logic                w_take;

    assign w_req  = {i_m1_req, i_m0_req};
    assign w_take = (r_state == ST_IDLE) && !i_rst && (w_req != 2'b00);

    rr_arbiter2 u_rr (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_last  <= RESET_LAST_B;
            r_owner <= M_CPU;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner <= w_winner;
                r_last  <= w_winner;
                r_addr  <= (w_winner == M_LDR) ? i_m1_addr  : i_m0_addr;
                r_wdata <= (w_winner == M_LDR) ? i_m1_wdata : i_m0_wdata;
                r_wmask <= (w_winner == M_LDR) ? i_m1_wmask : i_m0_wmask;
            end
        end
    end

    // address and write data simply hold the latch; only strobe/mask qualify an access
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        o_m0_gnt    = 1'b0;
        o_m1_gnt    = 1'b0;
        o_m0_rvalid = 1'b0;
        o_m1_rvalid = 1'b0;
        o_m0_rdata  = '0;
        o_m1_rdata  = '0;
        o_mem_strb  = 1'b0;
        o_mem_wmask = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    o_m0_gnt    = w_grant[0];
                    o_m1_gnt    = w_grant[1];
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_wmask != '0) begin
                    o_mem_wmask = r_wmask;
                    w_state_nxt = ST_IDLE;
                end else begin
                    o_mem_strb  = 1'b1;
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_owner == M_LDR) begin
                    o_m1_rvalid = 1'b1;
                    o_m1_rdata  = i_mem_rdata;
                end else begin
                    o_m0_rvalid = 1'b1;
                    o_m0_rdata  = i_mem_rdata;
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle synchronous memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    logic prev_gnt = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RESET_LAST(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_m0_req    (m0_req),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .i_m0_wmask  (m0_wmask),
        .o_m0_gnt    (m0_gnt),
        .o_m0_rvalid (m0_rvalid),
        .o_m0_rdata  (m0_rdata),
        .i_m1_req    (m1_req),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .i_m1_wmask  (m1_wmask),
        .o_m1_gnt    (m1_gnt),
        .o_m1_rvalid (m1_rvalid),
        .o_m1_rdata  (m1_rdata),
        .o_mem_strb  (mem_strb),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wmask (mem_wmask),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: byte lane i of the mask covers data bits [8i+7:8i]
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
        mem[8'h40] = 32'hDEAD_BEEF;
        mem[8'h81] = 32'hAABB_CCDD;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_strb) mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) prev_gnt <= m0_gnt | m1_gnt;

    always @(negedge clk) begin
        check("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'd0);
        check("rvalid_onehot", {31'b0, m0_rvalid & m1_rvalid}, 32'd0);
        check("gnt_in_rst", {31'b0, rst & (m0_gnt | m1_gnt)}, 32'd0);
        check("mem_only_issue", {31'b0, (mem_strb | (|mem_wmask)) & ~prev_gnt}, 32'd0);
    end

    initial begin
        int n;
        logic exp_owner;
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        tick;
        m0_req = 1'b1;
        tick;
        check("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
        check("rst_strb", {31'b0, mem_strb}, 32'd0);
        check("rst_wmask", {28'b0, mem_wmask}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        rst = 1'b0; m0_req = 1'b0;

        // 1: m0 read alone
        m0_req = 1'b1; m0_addr = 32'h100; #1;
        check("t1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0;
        check("t1_strb", {31'b0, mem_strb}, 32'd1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wmask", {28'b0, mem_wmask}, 32'd0);
        check("t1_early_rvalid", {31'b0, m0_rvalid}, 32'd0);
        tick;
        check("t1_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1_rdata1", m1_rdata, 32'd0);
        check("t1_strb_off", {31'b0, mem_strb}, 32'd0);
        tick;
        check("t1_rvalid_off", {31'b0, m0_rvalid}, 32'd0);

        // 2: m1 partial write then readback through m0
        m1_req = 1'b1; m1_addr = 32'h204; m1_wdata = 32'h1122_3344; m1_wmask = 4'b0011; #1;
        check("t2_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
        tick; m1_req = 1'b0; m1_wmask = '0;
        check("t2_wmask", {28'b0, mem_wmask}, 32'd3);
        check("t2_strb", {31'b0, mem_strb}, 32'd0);
        check("t2_addr", mem_addr, 32'h204);
        check("t2_wdata", mem_wdata, 32'h1122_3344);
        tick;
        check("t2_wmask_off", {28'b0, mem_wmask}, 32'd0);
        check("t2_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        m0_req = 1'b1; m0_addr = 32'h204; #1;
        check("t2_rb_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0;
        tick;
        check("t2_rb_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("t2_rb_rdata", m0_rdata, 32'hAABB_3344);
        tick;

        // 3: continuous contention from reset alternates m0, m1, ...
        rst = 1'b1; tick; rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h204;
        exp_owner = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n = 0; #1;
            while (!(m0_gnt | m1_gnt) && n < 8) begin tick; n++; end
            check("t3_gnt_timeout", {31'b0, n < 8}, 32'd1);
            check("t3_owner", {30'b0, m1_gnt, m0_gnt}, exp_owner ? 32'd2 : 32'd1);
            exp_owner = ~exp_owner;
            tick;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick; tick; tick;

        // 4: reset while a read is in ISSUE
        m0_req = 1'b1; m0_addr = 32'h100; #1;
        check("t4_gnt", {31'b0, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0; rst = 1'b1;
        check("t4_issue_strb", {31'b0, mem_strb}, 32'd1);
        tick;
        check("t4_abort_strb", {31'b0, mem_strb}, 32'd0);
        check("t4_abort_rvalid", {31'b0, m0_rvalid}, 32'd0);
        m0_req = 1'b1; #1;
        check("t4_gnt_in_rst", {31'b0, m0_gnt}, 32'd0);
        tick; rst = 1'b0;
        check("t4_no_rvalid", {31'b0, m0_rvalid}, 32'd0);
        #1;
        check("t4_regnt", {31'b0, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0;
        check("t4_strb", {31'b0, mem_strb}, 32'd1);
        check("t4_addr", mem_addr, 32'h100);
        tick;
        check("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t4_rvalid", {31'b0, m0_rvalid}, 32'd1);
        tick;

        // 5: back-to-back m0 reads; m1 raised mid-read overtakes
        m0_req = 1'b1; m0_addr = 32'h100; #1;
        check("t5_gnt_a", {31'b0, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0;
        tick;
        check("t5_rvalid_a", {31'b0, m0_rvalid}, 32'd1);
        m0_req = 1'b1; m0_addr = 32'h204; #1;
        check("t5_no_gnt_rdata", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        tick;
        check("t5_gnt_b", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h100;
        check("t5_strb_b", {31'b0, mem_strb}, 32'd1);
        tick;
        check("t5_rvalid_b", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
        check("t5_rdata_b", m0_rdata, 32'hAABB_3344);
        tick;
        check("t5_gnt_m1", {30'b0, m1_gnt, m0_gnt}, 32'd2);
        tick; m1_req = 1'b0;
        tick;
        check("t5_rvalid_m1", {30'b0, m1_rvalid, m0_rvalid}, 32'd2);
        check("t5_rdata_m1", m1_rdata, 32'hDEAD_BEEF);
        check("t5_rdata0_zero", m0_rdata, 32'd0);
        tick;
        check("t5_gnt_m0_last", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick; m0_req = 1'b0;
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
